// File: rtl/seq_ctrl_pkg.sv
// Shared constants for the sequence step controller: command op-codes,
// FSM state encoding and the values visited by the sequence.
package seq_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_CLEAR = 2'b00,
    OP_STEP  = 2'b01,
    OP_RUN   = 2'b10,
    OP_NOP   = 2'b11
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Sequence values in visiting order; after SEQ_V7 the sequence loops back to SEQ_V4.
  localparam logic [3:0] SEQ_V0 = 4'd0;
  localparam logic [3:0] SEQ_V1 = 4'd2;
  localparam logic [3:0] SEQ_V2 = 4'd5;
  localparam logic [3:0] SEQ_V3 = 4'd7;
  localparam logic [3:0] SEQ_V4 = 4'd8;
  localparam logic [3:0] SEQ_V5 = 4'd10;
  localparam logic [3:0] SEQ_V6 = 4'd9;
  localparam logic [3:0] SEQ_V7 = 4'd11;

  localparam logic [3:0] LOOP_MAX = 4'd15;

endpackage

// File: rtl/seq_next_lut.sv
// Combinational next-value table for the sequence, flagging the 11->8 wrap.
module seq_next_lut
  import seq_ctrl_pkg::*;
(
  input  logic [3:0] cur_i,
  output logic [3:0] next_o,
  output logic       wrap_o
);

  // Off-sequence values fall back to the start of the sequence.
  always_comb begin
    next_o = SEQ_V0;
    wrap_o = 1'b0;
    case (cur_i)
      SEQ_V0: next_o = SEQ_V1;
      SEQ_V1: next_o = SEQ_V2;
      SEQ_V2: next_o = SEQ_V3;
      SEQ_V3: next_o = SEQ_V4;
      SEQ_V4: next_o = SEQ_V5;
      SEQ_V5: next_o = SEQ_V6;
      SEQ_V6: next_o = SEQ_V7;
      SEQ_V7: begin
        next_o = SEQ_V4;
        wrap_o = 1'b1;
      end
      default: next_o = SEQ_V0;
    endcase
  end

endmodule

// File: rtl/seq_step_ctrl.sv
// Sequence step controller: accepts CLEAR/STEP/RUN commands in IDLE and
// advances the sequence once per cycle while a RUN is in progress.
module seq_step_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             halt,
  output logic [3:0]       q,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [15:0]      step_cnt,
  output logic [3:0]       loop_cnt
);

  state_e           state_q;
  logic [3:0]       q_q;
  logic [15:0]      step_cnt_q;
  logic [3:0]       loop_cnt_q;
  logic [LEN_W-1:0] remaining_q;
  logic             done_q;
  logic             aborted_q;

  logic [3:0]       q_d;
  logic             wrap;
  logic [15:0]      step_cnt_d;
  logic [3:0]       loop_cnt_d;

  seq_next_lut u_next (
    .cur_i  (q_q),
    .next_o (q_d),
    .wrap_o (wrap)
  );

  // Counter values to load whenever an advance happens.
  assign step_cnt_d = step_cnt_q + 16'd1;
  assign loop_cnt_d = (wrap && (loop_cnt_q != LOOP_MAX)) ? loop_cnt_q + 4'd1 : loop_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      q_q         <= SEQ_V0;
      step_cnt_q  <= '0;
      loop_cnt_q  <= '0;
      remaining_q <= '0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            case (op_e'(cmd_op))
              OP_CLEAR: begin
                q_q        <= SEQ_V0;
                step_cnt_q <= '0;
                loop_cnt_q <= '0;
                done_q     <= 1'b1;
              end
              OP_STEP: begin
                q_q        <= q_d;
                step_cnt_q <= step_cnt_d;
                loop_cnt_q <= loop_cnt_d;
                done_q     <= 1'b1;
              end
              OP_RUN: begin
                if (cmd_len == '0) begin
                  done_q <= 1'b1;
                end else begin
                  remaining_q <= cmd_len;
                  state_q     <= ST_RUN;
                end
              end
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          // Halt takes priority over any advance, including the final one.
          if (halt) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            done_q      <= 1'b1;
            aborted_q   <= 1'b1;
          end else begin
            q_q         <= q_d;
            step_cnt_q  <= step_cnt_d;
            loop_cnt_q  <= loop_cnt_d;
            remaining_q <= remaining_q - 1'b1;
            if (remaining_q == LEN_W'(1)) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_RUN);
  assign q         = q_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign step_cnt  = step_cnt_q;
  assign loop_cnt  = loop_cnt_q;

endmodule

// File: tb/tb_seq_step_ctrl.sv
// Self-checking bench for seq_step_ctrl: directed scenarios followed by random
// commands, compared against a transaction-level model of the sequence.
module tb_seq_step_ctrl;

  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [LEN_W-1:0] cmd_len;
  logic             halt;
  logic [3:0]       q;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [15:0]      step_cnt;
  logic [3:0]       loop_cnt;

  int checks = 0;
  int errors = 0;
  int mq, msteps, mloops;

  always #5 clk = ~clk;

  seq_step_ctrl #(.LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .halt      (halt),
    .q         (q),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .step_cnt  (step_cnt),
    .loop_cnt  (loop_cnt)
  );

  // Position-based view of the sequence: walk the visiting order, loop back to 8 after 11.
  function automatic int seqNext(input int v);
    int order [8] = '{0, 2, 5, 7, 8, 10, 9, 11};
    for (int i = 0; i < 8; i++)
      if (order[i] == v) return (i == 7) ? 8 : order[i + 1];
    return 0;
  endfunction

  task automatic modelAdvance();
    if (mq == 11) mloops = (mloops < 15) ? mloops + 1 : 15;
    mq     = seqNext(mq);
    msteps = (msteps + 1) % 65536;
  endtask

  task automatic modelClear();
    mq = 0; msteps = 0; mloops = 0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [LEN_W-1:0] len, input logic h);
    cmd_valid = v; cmd_op = op; cmd_len = len; halt = h;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, ".q"}, 32'(q), 32'(mq));
    checkOutput({tag, ".step_cnt"}, 32'(step_cnt), 32'(msteps));
    checkOutput({tag, ".loop_cnt"}, 32'(loop_cnt), 32'(mloops));
  endtask

  // Single-cycle command in IDLE; halt is randomised because IDLE must ignore it.
  task automatic doSimple(input logic [1:0] op);
    applyStimulus(1'b1, op, LEN_W'($urandom), 1'($urandom_range(0, 1)));
    cycle();
    applyStimulus(1'b0, 2'b00, '0, 1'b0);
    if (op == 2'b00) modelClear();
    else if (op == 2'b01) modelAdvance();
    checkOutput("simple.done", 32'(done), (op == 2'b11) ? 0 : 1);
    checkOutput("simple.aborted", 32'(aborted), 0);
    checkOutput("simple.busy", 32'(busy), 0);
    checkModel("simple");
    cycle();
    checkOutput("simple.done_clr", 32'(done), 0);
  endtask

  // RUN of len advances; haltAt>0 raises halt during that RUN cycle.
  task automatic doRun(input int len, input int haltAt);
    applyStimulus(1'b1, 2'b10, LEN_W'(len), 1'b0);
    cycle();
    applyStimulus(1'b0, 2'b00, '0, 1'b0);
    if (len == 0) begin
      checkOutput("run0.busy", 32'(busy), 0);
      checkOutput("run0.done", 32'(done), 1);
      checkOutput("run0.aborted", 32'(aborted), 0);
      checkModel("run0");
      cycle();
      checkOutput("run0.done_clr", 32'(done), 0);
      return;
    end
    checkOutput("run.busy_start", 32'(busy), 1);
    checkOutput("run.ready_start", 32'(cmd_ready), 0);
    checkOutput("run.q_start", 32'(q), 32'(mq));
    for (int c = 1; c <= len; c++) begin
      if (c == haltAt) begin
        halt = 1'b1;
        cycle();
        halt = 1'b0;
        checkOutput("halt.busy", 32'(busy), 0);
        checkOutput("halt.done", 32'(done), 1);
        checkOutput("halt.aborted", 32'(aborted), 1);
        checkModel("halt");
        cycle();
        checkOutput("halt.done_clr", 32'(done), 0);
        checkOutput("halt.aborted_clr", 32'(aborted), 0);
        return;
      end
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op    = 2'($urandom);
      cycle();
      cmd_valid = 1'b0;
      modelAdvance();
      checkOutput("run.q", 32'(q), 32'(mq));
      checkOutput("run.busy", 32'(busy), (c < len) ? 1 : 0);
      checkOutput("run.done", 32'(done), (c < len) ? 0 : 1);
      checkOutput("run.aborted", 32'(aborted), 0);
    end
    checkModel("run_end");
    cycle();
    checkOutput("run.done_clr", 32'(done), 0);
  endtask

  initial begin
    applyStimulus(1'b0, 2'b00, '0, 1'b0);
    rst = 1'b1;
    modelClear();
    cycle();
    cycle();
    checkOutput("rst.q", 32'(q), 0);
    checkOutput("rst.busy", 32'(busy), 0);
    checkOutput("rst.ready", 32'(cmd_ready), 1);
    checkOutput("rst.step_cnt", 32'(step_cnt), 0);
    checkOutput("rst.loop_cnt", 32'(loop_cnt), 0);
    checkOutput("rst.done", 32'(done), 0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) doSimple(2'b01);
    checkOutput("step4.q", 32'(q), 8);
    checkOutput("step4.step_cnt", 32'(step_cnt), 4);
    checkOutput("step4.loop_cnt", 32'(loop_cnt), 0);

    doSimple(2'b00);
    doRun(8, 0);
    checkOutput("run8.q", 32'(q), 8);
    checkOutput("run8.step_cnt", 32'(step_cnt), 8);
    checkOutput("run8.loop_cnt", 32'(loop_cnt), 1);

    doSimple(2'b00);
    doRun(20, 3);
    checkOutput("halt3.q", 32'(q), 5);
    checkOutput("halt3.step_cnt", 32'(step_cnt), 2);

    doRun(0, 0);
    checkOutput("run0.q_const", 32'(q), 5);

    doSimple(2'b11);

    doSimple(2'b00);
    doRun(70, 0);
    checkOutput("run70.loop_sat", 32'(loop_cnt), 15);
    doSimple(2'b00);
    checkOutput("clr.q", 32'(q), 0);
    checkOutput("clr.step_cnt", 32'(step_cnt), 0);
    checkOutput("clr.loop_cnt", 32'(loop_cnt), 0);

    // Reset arriving in the 4th RUN cycle.
    applyStimulus(1'b1, 2'b10, LEN_W'(10), 1'b0);
    cycle();
    applyStimulus(1'b0, 2'b00, '0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      cycle();
      modelAdvance();
    end
    checkOutput("prerst.q", 32'(q), 7);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    modelClear();
    checkOutput("runrst.q", 32'(q), 0);
    checkOutput("runrst.busy", 32'(busy), 0);
    checkOutput("runrst.ready", 32'(cmd_ready), 1);
    checkOutput("runrst.done", 32'(done), 0);
    cycle();
    checkOutput("runrst.done_after", 32'(done), 0);
    checkModel("runrst");

    for (int n = 0; n < 60; n++) begin
      int op, len, h;
      op = $urandom_range(0, 3);
      if (op == 2) begin
        len = $urandom_range(0, 24);
        h   = ($urandom_range(0, 2) == 0) ? $urandom_range(1, len + 1) : 0;
        doRun(len, (h > len) ? len : h);
      end else if (op == 0 && $urandom_range(0, 3) != 0) begin
        doSimple(2'b01);
      end else begin
        doSimple(2'(op));
      end
    end
    checkModel("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
